id_issue_stage: RTL
===================

Name: id_issue_stage

Overview:
Parametrised decode/operand-issue stage sitting between fetch and execute. It reads register operands through external regfile ports and resolves forwarding from NFWD in-flight producers with per-operand priority. It detects not-yet-ready producers and interlocks by inserting a bubble. Decoded fields and operands are held in an output pipeline register under a valid/ready handshake, with flush.

Parameters:
XLEN, 32, datapath width (>= 32)
NREG_BITS, 5, register index width
NFWD, 3, forwarding sources; index 0 = youngest (EX), higher = older
CTRL_W, 16, width of opaque decoded-control bundle passed through

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  kill held and incoming instruction
in_valid  in  1  fetch offers instruction
in_ready  out  1  stage accepts this cycle
instruction  in  32  fetched instruction
pc_next  in  XLEN  PC+4 of instruction
ctrl_in  in  CTRL_W  decoded control for instruction
uses_rs  in  1  instruction reads rs
uses_rt  in  1  instruction reads rt
rs_addr  out  NREG_BITS  regfile read address 1 = instruction[25:21]
rt_addr  out  NREG_BITS  regfile read address 2 = instruction[20:16]
rs_rdata  in  XLEN  regfile data 1
rt_rdata  in  XLEN  regfile data 2
fwd_we  in  NFWD  producer i will write a register
fwd_pending  in  NFWD  producer i data not yet available (load)
fwd_dst  in  NFWD*NREG_BITS  producer destinations, packed
fwd_data  in  NFWD*XLEN  producer data, packed
out_valid  out  1  execute-side entry valid
out_ready  in  1  execute accepts
out_data_s, out_data_t  out  XLEN  resolved operands
out_imm  out  XLEN  extended immediate
out_pc_jump  out  XLEN  {pc_next[XLEN-1:28], instruction[25:0], 2'b00}
out_pc_next  out  XLEN  passed pc_next
out_rs, out_rt, out_rd  out  NREG_BITS  instruction[25:21], [20:16], [15:11]
out_opcode, out_funct  out  6  instruction[31:26], [5:0]
out_ctrl  out  CTRL_W  passed ctrl_in
imm_zext  in  1  zero-extend immediate instead of sign-extend

Behaviour:
- Reset: every out_* = 0, out_valid = 0. Reset dominates all inputs.
- Forward select, independent per operand: lowest i with fwd_we[i] and fwd_dst[i] == addr and addr != 0 wins. If none matches, use regfile data.
- Register 0 is never forwarded and never stalls.
- Hazard: operand used (uses_rs/uses_rt) and its winning match has fwd_pending[i] = 1. A pending older match shadowed by a non-pending younger match is not a hazard.
- Advance: adv = ~out_valid | out_ready.
- in_ready = adv & ~hazard, or 1 when flush.
- Capture edge (in_valid & in_ready & ~flush):
  - load all out_* fields;
  - out_valid <= 1.
- Bubble (adv & in_valid & hazard & ~flush): out_valid <= 0; payload registers hold. The instruction is retried next cycle with fresh fwd_* inputs.
- No input with adv: out_valid <= 0.
- Hold (~adv): all outputs stable; payload never changes while out_valid & ~out_ready.
- Flush: out_valid <= 0 next edge, incoming instruction consumed and dropped. Flush has priority over capture, bubble and hold.
- Latency: 1 cycle from accept to out_valid; throughput 1/cycle absent hazard/backpressure.
- Immediate: imm_zext ? zero-extend instruction[15:0] : sign-extend, to XLEN.

Optional Feature:
STALL_CNT_EN defined:
- adds output stall_count (32): counts cycles with in_valid & hazard & ~flush;
- clears on reset;
- saturates at all-ones.
Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
Shared package holds:
- localparams for field offsets (OPC_HI=31, RS_LO=21, RT_LO=16, RD_LO=11, IMM_W=16, TGT_W=26);
- fwd-source index constants (FWD_EX=0, FWD_MEM=1, FWD_WB=2).
Sub-module fwd_mux:
- one instance per operand;
- does priority match, data select and pending/hazard flag;
- parameters NFWD, XLEN, NREG_BITS.

Test Plan:
- Reset held 2 cycles with in_valid=1 -> out_valid=0, all outputs 0, no capture.
- rs=5 (addr); regfile rs_rdata=0x11; fwd_dst[0]=5, fwd_data[0]=0xAA, fwd_we[0]=1; also fwd_dst[2]=5, fwd_data[2]=0xCC, fwd_we[2]=1 -> out_data_s=0xAA next cycle.
- rt=8, fwd_dst[0]=8, fwd_pending[0]=1, uses_rt=1 -> in_ready=0, out_valid=0. Next cycle pending=0, fwd_data[0]=0x1234 -> captured, out_data_t=0x1234.
- rs=0, fwd_dst[0]=0, fwd_we=1, pending=1 -> no stall, out_data_s=rs_rdata.
- out_valid=1, out_ready=0 for 3 cycles while instruction changes -> outputs unchanged, in_ready=0. Then flush=1 -> out_valid=0, in_ready=1.
- instruction[15:0]=0x8001: imm_zext=0 -> out_imm=0xFFFF8001; imm_zext=1 -> 0x00008001. Jump with pc_next=0x40000004 and target 0x0000010 -> out_pc_jump=0x40000040.

Source files
------------

// File: rtl/id_issue_stage_pkg.sv
// rtl/id_issue_stage_pkg.sv - shared field offsets and forwarding-source indices for the issue stage
package id_issue_stage_pkg;

    localparam int OPC_HI = 31;
    localparam int RS_LO  = 21;
    localparam int RT_LO  = 16;
    localparam int RD_LO  = 11;
    localparam int IMM_W  = 16;
    localparam int TGT_W  = 26;

    localparam int FWD_EX  = 0;
    localparam int FWD_MEM = 1;
    localparam int FWD_WB  = 2;

endpackage

// File: rtl/id_issue_stage_fwd_mux.sv
// rtl/id_issue_stage_fwd_mux.sv - per-operand forwarding priority match, data select and pending flag
module fwd_mux
    import id_issue_stage_pkg::*;
#(
    parameter int NFWD      = 3,
    parameter int XLEN      = 32,
    parameter int NREG_BITS = 5
) (
    input  logic [NREG_BITS-1:0]      addr,
    input  logic [XLEN-1:0]           rf_data,
    input  logic [NFWD-1:0]           fwd_we,
    input  logic [NFWD-1:0]           fwd_pending,
    input  logic [NFWD*NREG_BITS-1:0] fwd_dst,
    input  logic [NFWD*XLEN-1:0]      fwd_data,
    output logic [XLEN-1:0]           data,
    output logic                      pending
);

    // Walk oldest to youngest so the youngest matching producer is the last to assign.
    always_comb begin
        data    = rf_data;
        pending = 1'b0;
        for (int i = NFWD - 1; i >= FWD_EX; i--) begin
            if (fwd_we[i] && (addr != '0) && (fwd_dst[i*NREG_BITS +: NREG_BITS] == addr)) begin
                data    = fwd_data[i*XLEN +: XLEN];
                pending = fwd_pending[i];
            end
        end
    end

endmodule

// File: rtl/id_issue_stage.sv
// rtl/id_issue_stage.sv - decode/operand-issue stage with forwarding, load interlock and output register
// Optional STALL_CNT_EN adds a saturating stall_count output.
module id_issue_stage
    import id_issue_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NREG_BITS = 5,
    parameter int NFWD      = 3,
    parameter int CTRL_W    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               instruction,
    input  logic [XLEN-1:0]           pc_next,
    input  logic [CTRL_W-1:0]         ctrl_in,
    input  logic                      uses_rs,
    input  logic                      uses_rt,
    output logic [NREG_BITS-1:0]      rs_addr,
    output logic [NREG_BITS-1:0]      rt_addr,
    input  logic [XLEN-1:0]           rs_rdata,
    input  logic [XLEN-1:0]           rt_rdata,
    input  logic [NFWD-1:0]           fwd_we,
    input  logic [NFWD-1:0]           fwd_pending,
    input  logic [NFWD*NREG_BITS-1:0] fwd_dst,
    input  logic [NFWD*XLEN-1:0]      fwd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_data_s,
    output logic [XLEN-1:0]           out_data_t,
    output logic [XLEN-1:0]           out_imm,
    output logic [XLEN-1:0]           out_pc_jump,
    output logic [XLEN-1:0]           out_pc_next,
    output logic [NREG_BITS-1:0]      out_rs,
    output logic [NREG_BITS-1:0]      out_rt,
    output logic [NREG_BITS-1:0]      out_rd,
    output logic [5:0]                out_opcode,
    output logic [5:0]                out_funct,
    output logic [CTRL_W-1:0]         out_ctrl,
    input  logic                      imm_zext
`ifdef STALL_CNT_EN
    ,
    output logic [31:0]               stall_count
`endif
);

    logic [XLEN-1:0] data_s, data_t, imm_ext, pc_jump;
    logic            pend_s, pend_t, hazard, adv, capture;

    assign rs_addr = instruction[RS_LO +: NREG_BITS];
    assign rt_addr = instruction[RT_LO +: NREG_BITS];

    fwd_mux #(.NFWD(NFWD), .XLEN(XLEN), .NREG_BITS(NREG_BITS)) u_fwd_s (
        .addr(rs_addr), .rf_data(rs_rdata), .fwd_we(fwd_we), .fwd_pending(fwd_pending),
        .fwd_dst(fwd_dst), .fwd_data(fwd_data), .data(data_s), .pending(pend_s)
    );

    fwd_mux #(.NFWD(NFWD), .XLEN(XLEN), .NREG_BITS(NREG_BITS)) u_fwd_t (
        .addr(rt_addr), .rf_data(rt_rdata), .fwd_we(fwd_we), .fwd_pending(fwd_pending),
        .fwd_dst(fwd_dst), .fwd_data(fwd_data), .data(data_t), .pending(pend_t)
    );

    assign hazard   = (uses_rs & pend_s) | (uses_rt & pend_t);
    assign adv      = ~out_valid | out_ready;
    assign in_ready = flush | (adv & ~hazard);
    assign capture  = in_valid & in_ready & ~flush;

    assign imm_ext = imm_zext ? {{(XLEN-IMM_W){1'b0}}, instruction[IMM_W-1:0]}
                              : {{(XLEN-IMM_W){instruction[IMM_W-1]}}, instruction[IMM_W-1:0]};
    assign pc_jump = {pc_next[XLEN-1:TGT_W+2], instruction[TGT_W-1:0], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_data_s  <= '0;
            out_data_t  <= '0;
            out_imm     <= '0;
            out_pc_jump <= '0;
            out_pc_next <= '0;
            out_rs      <= '0;
            out_rt      <= '0;
            out_rd      <= '0;
            out_opcode  <= '0;
            out_funct   <= '0;
            out_ctrl    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv) begin
            // A stalled instruction leaves a bubble; the payload keeps its last value.
            out_valid <= capture;
            if (capture) begin
                out_data_s  <= data_s;
                out_data_t  <= data_t;
                out_imm     <= imm_ext;
                out_pc_jump <= pc_jump;
                out_pc_next <= pc_next;
                out_rs      <= instruction[RS_LO +: NREG_BITS];
                out_rt      <= instruction[RT_LO +: NREG_BITS];
                out_rd      <= instruction[RD_LO +: NREG_BITS];
                out_opcode  <= instruction[OPC_HI -: 6];
                out_funct   <= instruction[5:0];
                out_ctrl    <= ctrl_in;
            end
        end
    end

`ifdef STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (in_valid && hazard && !flush && (stall_count != '1)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule
